cmac_acc: RTL
=============

Name: cmac_acc

Overview:
- Pipelined complex multiply-accumulate for the PE datapath; generalises the single-shot complex MAC to a parametrised width.
- Adds optional conjugate of operand B, round-to-nearest on the output shift, and multi-sample frame accumulation in a guarded accumulator.
- Has a valid-tagged pipeline and a saturation flag.
- Feeds the PE result bus.

Parameters:
- DATA_WIDTH, 16: width of each real/imag component (two's complement).
- SHIFT_WIDTH, 5: width of the output right-shift amount.
- ACC_GUARD, 8: extra accumulator headroom bits above the 2*DATA_WIDTH+1 product sum.
- CNT_WIDTH, 8: width of the frame product counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset: synchronous, active-low.
- in_valid  in  1  sample strobe.
- in_last  in  1  final sample of the current frame (qualified by in_valid).
- acc_en  in  1  1 = frame accumulate, 0 = per-sample output.
- conj  in  1  1 = use conj(opb).
- rnd  in  1  round-half-up before the shift.
- shift  in  SHIFT_WIDTH  arithmetic right shift applied before saturation.
- opa  in  2*DATA_WIDTH  {real, imag}.
- opb  in  2*DATA_WIDTH  {real, imag}.
- out_valid  out  1  result strobe.
- out_data  out  2*DATA_WIDTH  {real, imag}, saturated.
- out_sat  out  1  either component saturated (qualified by out_valid).
- out_count  out  CNT_WIDTH  products in the emitted result (1 in per-sample mode).

Behaviour:
- Reset: rst_n is sampled on the clk rising edge. When low, all pipeline registers, the FSM, the counter and the accumulator clear. out_valid=0, out_data=0, out_sat=0, out_count=0.
- Reset mid-frame discards the frame and produces no output.
- Products:
  - conj=0: re = ar*br - ai*bi; im = ar*bi + ai*br.
  - conj=1: re = ar*br + ai*bi; im = ai*br - ar*bi.
  - Sums are signed at 2*DATA_WIDTH+1 bits, which is exact.
- Pipeline (input captured at edge k):
  - S1 at k: four signed partial products plus tags.
  - S2 at k+1: re/im sums.
  - S3 at k+2: accumulator.
  - OUT at k+3: shift, round, saturate.
  - out_valid is high for exactly one cycle after edge k+3, and only for emitting samples.
  - No backpressure. in_valid may be high every cycle.
- Tags carried with each sample: valid, first, last, emit, conj, rnd, shift.
- Input FSM, states IDLE and ACC:
  - IDLE, in_valid & !acc_en: the sample is tagged first=last=emit=1; state stays IDLE.
  - IDLE, in_valid & acc_en & !in_last: first=1, emit=0; latch conj/rnd/shift as the frame config; go to ACC.
  - IDLE, in_valid & acc_en & in_last: single-sample frame; first=last=emit=1.
  - ACC, in_valid: use the latched config. acc_en, conj, rnd and shift on the input are ignored until the frame ends. in_last → emit=1, return to IDLE.
  - ACC, !in_valid: bubble; state and accumulator hold.
- Accumulator (2*DATA_WIDTH+1+ACC_GUARD bits per component):
  - first sample loads the sum; other samples add to it.
  - Saturates at its own range and sets a sticky overflow that is ORed into out_sat.
  - Back-to-back frames need no gap: the first-tag load overrides the add.
- Counter: loads 1 on first, increments on each valid sample, saturates at all-ones. It travels with the S3 stage. out_count registers on emit.
- Output stage, per component:
  - If rnd and shift>0, add 1<<(shift-1).
  - Arithmetic right shift by shift.
  - Clamp to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]:
    - positive overflow → 0x7FFF (W=16);
    - negative overflow → 0x8000.
- out_sat = clamp hit on re or im, or accumulator sticky overflow.
- out_data, out_sat and out_count hold their last value when out_valid=0.

Decomposition:
- Package cmac_pkg:
  - state enum {IDLE, ACC};
  - pipeline tag struct;
  - localparams PROD_W = 2*DATA_WIDTH+1 and ACC_W = PROD_W+ACC_GUARD;
  - saturation max/min constants.
- One sub-module, cmac_rnd_sat: combinational round, shift and clamp for one component, with a sat flag. Instantiated twice (re, im).

Test Plan (DATA_WIDTH=16):
- Per-sample: opa=(3,4), opb=(5,-2), shift=0.
  - conj=0 → out_data={0x0017,0x000E}, valid 3 edges after capture, out_count=1.
  - conj=1 → {0x0007,0x001A}.
- Saturation, shift=0:
  - (0x7FFF,0)*(0x7FFF,0) → re 0x7FFF, out_sat=1.
  - Same operands with shift=15 → 0x7FFE, out_sat=0.
  - (0x8000,0)*(0x7FFF,0) → 0x8000, out_sat=1.
- Rounding: re product 3, shift=1 → rnd=1 gives 2, rnd=0 gives 1. Product −3 → rnd=1 gives −1, rnd=0 gives −2.
- Frame: 4 samples opa=(1,1), opb=(1,1), acc_en=1, last on sample 4.
  - In between, insert 2 bubbles and change shift to 3 mid-frame (must be ignored).
  - Expect a single out_valid with {0x0000,0x0008} and out_count=4.
- Back-to-back frames: frame A (1 sample, product (0,2)) immediately followed by frame B (2 samples, each (0,2)) → outputs (0,2) count 1, then (0,4) count 2.
- Reset mid-frame: after 2 accumulated samples, hold rst_n low for 1 cycle.
  - No out_valid follows.
  - The next 1-sample frame yields its own product only.

Source files
------------

// File: rtl/cmac_pkg.sv
// Shared types and constants for the pipelined complex multiply-accumulate.
package cmac_pkg;

    // Default geometry of the PE datapath instance.
    localparam int DEF_DATA_WIDTH  = 16;
    localparam int DEF_SHIFT_WIDTH = 5;
    localparam int DEF_ACC_GUARD   = 8;
    localparam int DEF_CNT_WIDTH   = 8;

    // Exact width of a complex product component, and the guarded accumulator width.
    localparam int PROD_W = 2 * DEF_DATA_WIDTH + 1;
    localparam int ACC_W  = PROD_W + DEF_ACC_GUARD;

    // Output clamp limits for the default component width.
    localparam logic [DEF_DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_DATA_WIDTH-1){1'b1}}};
    localparam logic [DEF_DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_DATA_WIDTH-1){1'b0}}};

    // Input framing FSM.
    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    // Per-sample control tag that travels down the pipeline next to the data.
    // The shift amount travels in a parallel register because its width is a
    // parameter of the instantiating module.
    typedef struct packed {
        logic valid;
        logic first;
        logic last;
        logic emit;
        logic conj;
        logic rnd;
    } tag_t;

endpackage

// File: rtl/cmac_rnd_sat.sv
// Round-half-up, arithmetic right shift and clamp of one accumulator component.
module cmac_rnd_sat #(
    parameter int IN_W        = 41,
    parameter int OUT_W       = 16,
    parameter int SHIFT_WIDTH = 5
) (
    input  logic signed [IN_W-1:0]        din,
    input  logic        [SHIFT_WIDTH-1:0] shift,
    input  logic                          rnd,
    output logic        [OUT_W-1:0]       dout,
    output logic                          sat
);

    // One extra bit so the rounding bias can never wrap the value.
    localparam logic signed [IN_W:0] ONE  = (IN_W+1)'(1);
    localparam logic signed [IN_W:0] MAXV = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [IN_W:0] MINV = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [IN_W:0] bias;
    logic signed [IN_W:0] rounded;
    logic signed [IN_W:0] shifted;

    // Bias, shift and clamp in one combinational pass.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
        bias = '0;
        dout = '0;
        sat  = 1'b0;
        if (rnd && (shift != '0)) begin
            bias = ONE << (shift - SHIFT_WIDTH'(1));
        end
        rounded = {din[IN_W-1], din} + bias;
        shifted = rounded >>> shift;
        if (shifted > MAXV) begin
            dout = {1'b0, {(OUT_W-1){1'b1}}};
            sat  = 1'b1;
        end else if (shifted < MINV) begin
            dout = {1'b1, {(OUT_W-1){1'b0}}};
            sat  = 1'b1;
        end else begin
            dout = shifted[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/cmac_acc.sv
// Pipelined complex MAC with optional conj(B), frame accumulation and
// round/shift/saturate output stage. Four register stages, no backpressure.
module cmac_acc
    import cmac_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SHIFT_WIDTH = DEF_SHIFT_WIDTH,
    parameter int ACC_GUARD   = DEF_ACC_GUARD,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_last,
    input  logic                    acc_en,
    input  logic                    conj,
    input  logic                    rnd,
    input  logic [SHIFT_WIDTH-1:0]  shift,
    input  logic [2*DATA_WIDTH-1:0] opa,
    input  logic [2*DATA_WIDTH-1:0] opb,
    output logic                    out_valid,
    output logic [2*DATA_WIDTH-1:0] out_data,
    output logic                    out_sat,
    output logic [CNT_WIDTH-1:0]    out_count
);

    localparam int W  = DATA_WIDTH;
    localparam int PW = 2 * W + 1;
    localparam int AW = PW + ACC_GUARD;

    localparam logic signed [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic signed [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic signed [W-1:0] ar, ai, br, bi;
    assign ar = opa[2*W-1:W];
    assign ai = opa[W-1:0];
    assign br = opb[2*W-1:W];
    assign bi = opb[W-1:0];

    state_t                 state;
    logic                   cfg_conj;
    logic                   cfg_rnd;
    logic [SHIFT_WIDTH-1:0] cfg_shift;

    tag_t                   s1_tag, s2_tag, s3_tag;
    logic [SHIFT_WIDTH-1:0] s1_shift, s2_shift, s3_shift;
    logic signed [2*W-1:0]  pp_rr, pp_ii, pp_ri, pp_ir;
    logic signed [PW-1:0]   s2_re, s2_im;
    logic signed [AW-1:0]   acc_re, acc_im;
    logic                   acc_ovf;
    logic [CNT_WIDTH-1:0]   cnt;

    logic signed [AW:0]     add_re, add_im;
    logic                   ovf_re, ovf_im;
    logic signed [AW-1:0]   sat_re, sat_im;

    logic [W-1:0]           res_re, res_im;
    logic                   clip_re, clip_im;

    // Framing FSM: tags each accepted sample and latches the frame config on frame start.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state     <= IDLE;
            cfg_conj  <= 1'b0;
            cfg_rnd   <= 1'b0;
            cfg_shift <= '0;
            s1_tag    <= '0;
            s1_shift  <= '0;
        end else begin
            s1_tag <= '0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        s1_shift <= shift;
                        if (acc_en && !in_last) begin
                            s1_tag    <= '{valid: 1'b1, first: 1'b1, last: 1'b0, emit: 1'b0,
                                           conj: conj, rnd: rnd};
                            cfg_conj  <= conj;
                            cfg_rnd   <= rnd;
                            cfg_shift <= shift;
                            state     <= ACC;
                        end else begin
                            s1_tag <= '{valid: 1'b1, first: 1'b1, last: 1'b1, emit: 1'b1,
                                        conj: conj, rnd: rnd};
                        end
                    end
                    ACC: begin
                        s1_shift <= cfg_shift;
                        s1_tag   <= '{valid: 1'b1, first: 1'b0, last: in_last, emit: in_last,
                                      conj: cfg_conj, rnd: cfg_rnd};
                        if (in_last) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // S1: the four signed partial products of the sample.
    always_ff @(posedge clk) begin
        // NOTE: datapath registers are cleared too, so a reset leaves no stale operands anywhere in the pipe.
        if (!rst_n) begin
            pp_rr <= '0;
            pp_ii <= '0;
            pp_ri <= '0;
            pp_ir <= '0;
        end else if (in_valid) begin
            pp_rr <= (2*W)'(ar) * (2*W)'(br);
            pp_ii <= (2*W)'(ai) * (2*W)'(bi);
            pp_ri <= (2*W)'(ar) * (2*W)'(bi);
            pp_ir <= (2*W)'(ai) * (2*W)'(br);
        end
    end

    // S2: combine partial products into the exact real/imag sums.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_re    <= '0;
            s2_im    <= '0;
            s2_tag   <= '0;
            s2_shift <= '0;
        end else begin
            s2_tag   <= s1_tag;
            s2_shift <= s1_shift;
            if (s1_tag.conj) begin
                s2_re <= PW'(pp_rr) + PW'(pp_ii);
                s2_im <= PW'(pp_ir) - PW'(pp_ri);
            end else begin
                s2_re <= PW'(pp_rr) - PW'(pp_ii);
                s2_im <= PW'(pp_ri) + PW'(pp_ir);
            end
        end
    end

    // Saturating add of the incoming sum onto the running accumulator.
    always_comb begin
        add_re = {acc_re[AW-1], acc_re} + (AW+1)'(s2_re);
        add_im = {acc_im[AW-1], acc_im} + (AW+1)'(s2_im);
        ovf_re = add_re[AW] ^ add_re[AW-1];
        ovf_im = add_im[AW] ^ add_im[AW-1];
        sat_re = ovf_re ? (add_re[AW] ? ACC_MIN : ACC_MAX) : add_re[AW-1:0];
        sat_im = ovf_im ? (add_im[AW] ? ACC_MIN : ACC_MAX) : add_im[AW-1:0];
    end

    // S3: accumulator and product counter; a first tag loads and so needs no gap between frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_re   <= '0;
            acc_im   <= '0;
            acc_ovf  <= 1'b0;
            cnt      <= '0;
            s3_tag   <= '0;
            s3_shift <= '0;
        end else begin
            s3_tag   <= s2_tag;
            s3_shift <= s2_shift;
            if (s2_tag.valid) begin
                if (s2_tag.first) begin
                    acc_re  <= AW'(s2_re);
                    acc_im  <= AW'(s2_im);
                    acc_ovf <= 1'b0;
                    cnt     <= CNT_WIDTH'(1);
                end else begin
                    acc_re  <= sat_re;
                    acc_im  <= sat_im;
                    acc_ovf <= acc_ovf | ovf_re | ovf_im;
                    if (!(&cnt)) begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
            end
        end
    end

    cmac_rnd_sat #(
        .IN_W        (AW),
        .OUT_W       (W),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_rnd_sat_re (
        .din   (acc_re),
        .shift (s3_shift),
        .rnd   (s3_tag.rnd),
        .dout  (res_re),
        .sat   (clip_re)
    );

    cmac_rnd_sat #(
        .IN_W        (AW),
        .OUT_W       (W),
        .SHIFT_WIDTH (SHIFT_WIDTH)
    ) u_rnd_sat_im (
        .din   (acc_im),
        .shift (s3_shift),
        .rnd   (s3_tag.rnd),
        .dout  (res_im),
        .sat   (clip_im)
    );

    // OUT: register the result on emitting samples only; data fields hold otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_count <= '0;
        end else begin
            out_valid <= s3_tag.valid & s3_tag.emit;
            if (s3_tag.valid && s3_tag.emit) begin
                out_data  <= {res_re, res_im};
                out_sat   <= clip_re | clip_im | acc_ovf;
                out_count <= cnt;
            end
        end
    end

    // Tag fields that are not consumed after the accumulator stage.
    logic unused_tags;
    assign unused_tags = ^{s3_tag.first, s3_tag.last, s3_tag.conj};

endmodule
